// File: rtl/aes_arbiter_pkg.sv
// Shared definitions for the AES arbiter slice: FSM encoding, watchdog
// defaults, the captured-job record and small one-hot/selection helpers.
package aes_arbiter_pkg;

  // Default watchdog limit (WAIT cycles) and the counter width that holds it.
  localparam int TIMEOUT_DEF = 1024;
  localparam int CNT_W_DEF   = 11;

  // Sequencer state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // One job as presented to the AES core.
  typedef struct packed {
    logic         dec;
    logic [127:0] key;
    logic [127:0] text;
  } aes_job_t;

  localparam aes_job_t JOB_NONE = '{dec: 1'b0, key: 128'd0, text: 128'd0};

  // Operands of the requester selected by idx.
  function automatic aes_job_t pick_job(input logic idx, input aes_job_t job0,
                                        input aes_job_t job1);
    aes_job_t res;
    if (idx) begin
      res = job1;
    end else begin
      res = job0;
    end
    return res;
  endfunction

  // Route a single pulse to the requester slot named by idx: {slot1, slot0}.
  function automatic logic [1:0] owner_onehot(input logic idx, input logic en);
    return {idx & en, ~idx & en};
  endfunction

endpackage

// File: rtl/aes_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick. A lone requester wins; on a tie the
// requester that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Winner selection from the request pair and the previous winner.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 1'b0;
    case (req)
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_idx   = 1'b0;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_idx   = 1'b1;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        gnt_idx   = ~last;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/aes_arbiter.sv
// Two-requester arbiter and sequencer for a shared AES core. Grants the core
// round-robin, captures the winner's operands, pulses start, waits for the
// core under a watchdog and hands the result (or an error) back to the owner.
module aes_arbiter
  import aes_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Req0,
  input  logic         i_Req1,
  input  logic         i_Dec0,
  input  logic         i_Dec1,
  input  logic [127:0] i_Key0,
  input  logic [127:0] i_Key1,
  input  logic [127:0] i_Text0,
  input  logic [127:0] i_Text1,
  output logic         o_Ack0,
  output logic         o_Ack1,
  output logic         o_Done0,
  output logic         o_Done1,
  output logic         o_Err0,
  output logic         o_Err1,
  output logic [127:0] o_Text,
  output logic         o_Busy,
  output logic         o_Owner,
  output logic         o_AesStart,
  output logic         o_AesDec,
  output logic [127:0] o_AesKey,
  output logic [127:0] o_AesText,
  input  logic         i_AesDone,
  input  logic [127:0] i_AesText
);

  // Watchdog terminal count and increment, sized to the counter.
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       c_state, n_state;
  logic [CNT_W-1:0] c_cnt,   n_cnt;
  logic             c_last,  n_last;
  logic             c_owner, n_owner;
  logic             c_busy,  n_busy;
  logic [1:0]       c_ack,   n_ack;
  logic [1:0]       c_done,  n_done;
  logic [1:0]       c_err,   n_err;
  logic             c_start, n_start;
  logic [127:0]     c_text,  n_text;
  aes_job_t         c_job,   n_job;

  logic             gnt_valid_s;
  logic             gnt_idx_s;
  aes_job_t         job0_s;
  aes_job_t         job1_s;
  aes_job_t         grant_job_s;

  assign job0_s      = '{dec: i_Dec0, key: i_Key0, text: i_Text0};
  assign job1_s      = '{dec: i_Dec1, key: i_Key1, text: i_Text1};
  assign grant_job_s = pick_job(gnt_idx_s, job0_s, job1_s);

  rr_arb2 u_rr_arb2 (
    .req       ({i_Req1, i_Req0}),
    .last      (c_last),
    .gnt_valid (gnt_valid_s),
    .gnt_idx   (gnt_idx_s)
  );

  // Next-state logic for the sequencer, watchdog, operands and output pulses.
  always_comb begin
    n_state = c_state;
    n_cnt   = c_cnt;
    n_last  = c_last;
    n_owner = c_owner;
    n_job   = c_job;
    n_text  = c_text;
    n_ack   = 2'b00;
    n_done  = 2'b00;
    n_err   = 2'b00;
    n_start = 1'b0;
    case (c_state)
      ST_IDLE: begin
        // The grant decision is only taken here; requests seen in any other
        // state simply wait, since they are level-held by the requester.
        if (gnt_valid_s) begin
          n_state = ST_START;
          n_owner = gnt_idx_s;
          n_last  = gnt_idx_s;
          n_job   = grant_job_s;
          n_ack   = owner_onehot(gnt_idx_s, 1'b1);
          n_start = 1'b1;
          n_cnt   = {CNT_W{1'b0}};
        end else begin
          n_state = ST_IDLE;
        end
      end
      ST_START: begin
        n_state = ST_WAIT;
        n_cnt   = {CNT_W{1'b0}};
      end
      ST_WAIT: begin
        n_cnt = c_cnt + CNT_ONE;
        // A completion in the terminal-count cycle still counts as success.
        if (i_AesDone) begin
          n_state = ST_RESP;
          n_text  = i_AesText;
          n_done  = owner_onehot(c_owner, 1'b1);
        end else if (c_cnt == CNT_TERM) begin
          n_state = ST_RESP;
          n_text  = 128'd0;
          n_done  = owner_onehot(c_owner, 1'b1);
          n_err   = owner_onehot(c_owner, 1'b1);
        end else begin
          n_state = ST_WAIT;
        end
      end
      ST_RESP: begin
        n_state = ST_IDLE;
      end
      default: begin
        n_state = ST_IDLE;
      end
    endcase
    n_busy = (n_state != ST_IDLE);
  end

  // State and output registers; reset returns everything to idle defaults.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      c_state <= ST_IDLE;
      c_cnt   <= {CNT_W{1'b0}};
      c_last  <= 1'b1;
      c_owner <= 1'b0;
      c_busy  <= 1'b0;
      c_ack   <= 2'b00;
      c_done  <= 2'b00;
      c_err   <= 2'b00;
      c_start <= 1'b0;
      c_text  <= 128'd0;
      c_job   <= JOB_NONE;
    end else begin
      c_state <= n_state;
      c_cnt   <= n_cnt;
      c_last  <= n_last;
      c_owner <= n_owner;
      c_busy  <= n_busy;
      c_ack   <= n_ack;
      c_done  <= n_done;
      c_err   <= n_err;
      c_start <= n_start;
      c_text  <= n_text;
      c_job   <= n_job;
    end
  end

  assign o_Ack0     = c_ack[0];
  assign o_Ack1     = c_ack[1];
  assign o_Done0    = c_done[0];
  assign o_Done1    = c_done[1];
  assign o_Err0     = c_err[0];
  assign o_Err1     = c_err[1];
  assign o_Text     = c_text;
  assign o_Busy     = c_busy;
  assign o_Owner    = c_owner;
  assign o_AesStart = c_start;
  assign o_AesDec   = c_job.dec;
  assign o_AesKey   = c_job.key;
  assign o_AesText  = c_job.text;

endmodule
